mem_bist_ctrl: RTL
==================

Name: mem_bist_ctrl

Overview:
- Synthesizable initiator for the lab memory interface. It replaces the behavioural memory test with an RTL controller that drives the memory's read, write, addr and data_in pins.
- On `start` it writes a selected pattern to every address, reads every address back, and compares the returned data against the expected value.
- It reports pass/fail, an error count and the first failing location.
- Sits beside `mem` in `top`, connected to the memory-side signals of `mem_interf`.

Parameters:
- ADDR_WIDTH, 5, memory address width; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, memory data width.
- RD_LATENCY, 1, cycles from the `mem_read` sample edge to valid `mem_rdata`; legal range 1..4.

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a test; ignored while busy.
- pattern_sel  in  2  pattern code, latched at start.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  write data, driven to memory data_in.
- mem_rdata  in  DATA_WIDTH  read data, driven from memory data_out.
- busy  out  1  high while a test is running.
- done  out  1  high from test completion until the next accepted start.
- pass  out  1  valid while done=1; high when err_count==0.
- err_count  out  ADDR_WIDTH+1  number of miscompares.
- fail_addr  out  ADDR_WIDTH  address of the first miscompare.
- fail_data  out  DATA_WIDTH  data read at the first miscompare.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0: mem_read, mem_write, mem_addr, mem_wdata, busy, done, pass, err_count, fail_addr, fail_data.
  - Reset is honoured mid-test; any in-flight reads are discarded.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- Start acceptance:
  - In IDLE or DONE, start=1 at an edge latches pattern_sel.
  - On the same edge it clears err_count, fail_addr, fail_data, done and pass, sets busy, and moves to WRITE with addr counter = 0.
  - start in WRITE, READ or DRAIN has no effect.
- Expected data exp(a):
  - Code 0: a zero-extended or truncated to DATA_WIDTH.
  - Code 1: bitwise inverse of code 0.
  - Code 2: checkerboard; 0x55..55 for even a, 0xAA..AA for odd a.
  - Code 3: constant 0xA5 replicated or truncated to DATA_WIDTH.
- WRITE state:
  - mem_write=1, mem_addr=a, mem_wdata=exp(a); one write per cycle, a = 0..DEPTH-1.
  - After a=DEPTH-1 the state moves to READ with a=0.
- READ state:
  - mem_read=1, mem_addr=a; one read per cycle, a = 0..DEPTH-1.
  - After the last issue the state moves to DRAIN.
  - mem_wdata holds its last value, a don't-care for the memory.
- Compare pipeline:
  - A RD_LATENCY-deep shift register carries {valid, addr} for each issued read.
  - Expected data is recomputed from the delayed address.
  - mem_rdata is compared when the delayed valid is 1.
  - On mismatch err_count increments; on the first mismatch only, fail_addr and fail_data are captured.
- DRAIN: no strobes; it waits RD_LATENCY cycles until the pipeline is empty, then moves to DONE.
- DONE: busy=0, done=1, pass=(err_count==0); results hold until the next accepted start.
- Exclusivity: mem_read and mem_write are never high together, and both are 0 in IDLE, DRAIN and DONE.
- Timing: with start sampled at edge 0:
  - Writes are active in cycles 1..DEPTH.
  - Reads are active in cycles DEPTH+1..2*DEPTH.
  - done rises at edge 2*DEPTH+RD_LATENCY+1.
- Width rule: err_count maximum is DEPTH, so it never wraps; the address counter wraps only at phase transitions.

Test Plan:
1. Reset, then start with pattern_sel=0 against a good mem, ADDR_WIDTH=5 → 32 writes with data 0x00..0x1F, 32 reads; done rises 65+RD_LATENCY cycles after the start edge; pass=1, err_count=0.
2. pattern_sel=2 → write data alternates 0x55 at address 0 and 0xAA at address 1; pass=1; check mem_read and mem_write are never high together.
3. Memory model with data bit 3 stuck at 1, pattern_sel=0 → err_count=16, fail_addr=0x00, fail_data=0x08, pass=0.
4. Pulse start during the READ state → no restart, and completion timing is unchanged. A second start in DONE with pattern_sel=3 → results clear, all writes are 0xA5, pass=1.
5. Deassert rst_n mid-WRITE (cycle 10) → all outputs are 0 immediately without waiting for an edge. After release, a fresh start completes normally with pass=1.
6. RD_LATENCY=3 with a matching 3-cycle memory model, pattern_sel=1 → writes 0xFF..0xE0, pass=1; done rises at edge 68.

Source files
------------

// File: rtl/mem_bist_ctrl.sv
// Memory built-in self-test initiator: writes a pattern to every word, reads it back
// through a latency-matched compare pipeline and reports pass/fail plus the first failure.
module mem_bist_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            pattern_sel,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    accept;
    logic                    last_addr;
    logic                    miscompare;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              pat_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   exp_wr, exp_rd;
    logic [RD_LATENCY-1:0]   pipe_vld;
    logic [ADDR_WIDTH-1:0]   pipe_addr [RD_LATENCY];

    function automatic logic [DATA_WIDTH-1:0] exp_data(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [1:0] code);
        logic [DATA_WIDTH-1:0] d;
        logic [7:0]            a5;
        a5 = 8'hA5;
        d  = '0;
        case (code)
            2'd0: d = DATA_WIDTH'(a);
            2'd1: d = ~DATA_WIDTH'(a);
            2'd2: for (int i = 0; i < DATA_WIDTH; i++) d[i] = (i % 2 == 0) ^ a[0];
            default: for (int i = 0; i < DATA_WIDTH; i++) d[i] = a5[i % 8];
        endcase
        return d;
    endfunction

    assign last_addr  = (addr_q == {ADDR_WIDTH{1'b1}});
    assign exp_wr     = exp_data(addr_q, pat_q);
    assign exp_rd     = exp_data(pipe_addr[RD_LATENCY-1], pat_q);
    assign miscompare = pipe_vld[RD_LATENCY-1] && (mem_rdata != exp_rd);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_d   = state_q;
        accept    = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    accept  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_wdata = exp_wr;
                if (last_addr) state_d = READ;
            end
            READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (last_addr) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pipe_vld == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        pass = done && (err_count == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            pat_q     <= '0;
            wdata_q   <= '0;
            pipe_vld  <= '0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            pipe_vld <= (pipe_vld << 1) | RD_LATENCY'(mem_read);
            if (mem_write) wdata_q <= exp_wr;
            if (accept) begin
                addr_q    <= '0;
                pat_q     <= pattern_sel;
                err_count <= '0;
                fail_addr <= '0;
                fail_data <= '0;
            end else begin
                // The counter wraps to 0 exactly at the WRITE->READ and READ->DRAIN boundaries.
                if (mem_write || mem_read) addr_q <= addr_q + 1'b1;
                if (miscompare) begin
                    if (err_count == '0) begin
                        fail_addr <= pipe_addr[RD_LATENCY-1];
                        fail_data <= mem_rdata;
                    end
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

    // NOTE: the address pipeline is qualified by pipe_vld, so it needs no reset and stays plain flops.
    always_ff @(posedge clk) begin
        pipe_addr[0] <= addr_q;
        for (int i = 1; i < RD_LATENCY; i++) pipe_addr[i] <= pipe_addr[i-1];
    end

endmodule
